sync_event_generator: RTL and testbench
=======================================

Name: sync_event_generator

Overview:
- Programmable synchronous event source that emits exactly cfg_rate single-cycle event pulses per window of WINDOW_CYCLES clocks.
- Pulses are spread evenly across the window using a Bresenham-style phase accumulator.
- Acts as the transmit-side counterpart of the synchronous event counter: its event_out drives a counter's event input for self-test and calibration.
- Reports per-window emitted count and a window-done strobe.

Parameters:
- WINDOW_CYCLES, 100_000_000, window length in clk cycles (must be >= 2).
- COUNT_W, 32, width of rate, counters and emitted-count output.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high.
- cfg_valid  input  1  config offer; transfer occurs on a cycle with cfg_valid & cfg_ready.
- cfg_ready  output  1  high when no pending config is held in the shadow register.
- cfg_rate  input  COUNT_W  requested events per window; values above WINDOW_CYCLES are clamped to WINDOW_CYCLES at acceptance.
- start  input  1  single-cycle request to begin generating; ignored unless in IDLE.
- stop  input  1  single-cycle request to finish the current window, then go idle.
- event_out  output  1  registered single-cycle event pulse.
- window_done  output  1  registered single-cycle strobe at the end of each window.
- events_emitted  output  COUNT_W  events emitted in the last completed window; held between windows.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (clock clk; reset is synchronous, active-high):
  - Outputs: event_out=0, window_done=0, events_emitted=0, busy=0, cfg_ready=1.
  - State: state=IDLE, active_rate=0, shadow cleared, acc=0, cyc=0, run_cnt=0.
  - Reset asserted mid-window aborts the window without a window_done strobe; outputs take reset values on the next edge.
- Config handshake:
  - On an accepted transfer, the clamped rate is stored in the shadow register, a pending flag is set, and cfg_ready drops.
  - In IDLE, a pending shadow is copied to active_rate on the next cycle; pending clears and cfg_ready rises.
  - In RUN/STOPPING, the shadow is copied only at a window boundary (same edge as window_done). Active rate never changes mid-window.
- State machine:
  - IDLE: on start, go to ARM.
  - ARM (one cycle): apply any pending shadow; clear acc, cyc and run_cnt; go to RUN.
  - RUN: every cycle:
    - sum = acc + active_rate, computed in COUNT_W+1 bits.
    - If sum >= WINDOW_CYCLES: acc <= sum - WINDOW_CYCLES, event_out <= 1, run_cnt increments; otherwise acc <= sum, event_out <= 0.
    - cyc increments each cycle.
  - Window end: when cyc == WINDOW_CYCLES-1, on that edge:
    - window_done <= 1.
    - events_emitted <= run_cnt plus that cycle's event.
    - cyc <= 0, acc <= 0, run_cnt <= 0.
    - Pending shadow is applied.
  - stop seen in RUN: go to STOPPING. STOPPING behaves like RUN; at window end it strobes window_done and goes to IDLE.
  - stop in IDLE or ARM is ignored. start outside IDLE is ignored. start and stop in the same IDLE cycle: start wins.
- Guarantees:
  - Exactly active_rate events per completed window; at most one event per cycle.
  - rate 0 produces no events; rate == WINDOW_CYCLES produces event_out high every RUN cycle.
- Latency:
  - First RUN cycle is 2 cycles after start is sampled.
  - event_out is visible 1 cycle after the RUN cycle that produced it.

Optional Feature:
- Macro: SYNC_EVENT_GEN_ONE_SHOT_EN.
- When defined: an extra input port one_shot (1 bit) exists and is sampled in IDLE together with start. If one_shot=1, the block runs exactly one window, then returns to IDLE as if stop had been issued.
- When undefined: the port is absent and the block free-runs windows until stop.

Test Plan:
All scenarios use WINDOW_CYCLES=10.
- Rate 3 accepted in IDLE, then start -> events at window cycles 3, 6, 9 (event_out one cycle later); window_done once per 10 RUN cycles; events_emitted=3.
- Rate 0 and then rate 15 (clamped to 10) -> emitted 0 with no event_out; then event_out high all 10 cycles, emitted 10.
- Rate 3 running; rate 7 accepted at window cycle 4 -> cfg_ready low until boundary; current window emits 3; next window emits 7; cfg_ready returns high at the boundary.
- stop at window cycle 2 -> window completes; window_done strobes; events_emitted=3; busy drops the cycle after the final window_done; no further events.
- reset at window cycle 5 with rate 5 -> next cycle all outputs 0, state IDLE, no window_done; a later start produces a clean 5-event window.
- SYNC_EVENT_GEN_ONE_SHOT_EN defined, start with one_shot=1 and rate 4 -> exactly one window; 4 events; single window_done; then busy=0.

Source files
------------

// File: rtl/sync_event_generator.sv
// rtl/sync_event_generator.sv - spreads cfg_rate event pulses evenly over each WINDOW_CYCLES window.
// Optional one-window mode: define SYNC_EVENT_GEN_ONE_SHOT_EN to add the one_shot input.
module sync_event_generator #(
  parameter int unsigned WINDOW_CYCLES = 100_000_000,
  parameter int unsigned COUNT_W       = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [COUNT_W-1:0] cfg_rate,
  input  logic               start,
  input  logic               stop,
`ifdef SYNC_EVENT_GEN_ONE_SHOT_EN
  input  logic               one_shot,
`endif
  output logic               event_out,
  output logic               window_done,
  output logic [COUNT_W-1:0] events_emitted,
  output logic               busy
);

  localparam logic [COUNT_W-1:0] WIN      = COUNT_W'(WINDOW_CYCLES);
  localparam logic [COUNT_W-1:0] WIN_LAST = COUNT_W'(WINDOW_CYCLES - 1);
  localparam logic [COUNT_W:0]   WIN_EXT  = {1'b0, WIN};

  typedef enum logic [1:0] {IDLE, ARM, RUN, STOPPING} state_t;

  state_t             state;
  logic [COUNT_W-1:0] active_rate;
  logic [COUNT_W-1:0] shadow_rate;
  logic               pending;
  logic [COUNT_W-1:0] acc;
  logic [COUNT_W-1:0] cyc;
  logic [COUNT_W-1:0] run_cnt;
`ifdef SYNC_EVENT_GEN_ONE_SHOT_EN
  logic               one_shot_q;
`endif

  logic [COUNT_W:0]   sum;
  logic               hit;
  logic               win_end;
  logic               accept;
  logic [COUNT_W-1:0] rate_clamped;
  logic [COUNT_W-1:0] acc_next;

  // The accumulator never exceeds WINDOW_CYCLES-1, so one extra bit holds acc+rate.
  assign sum          = {1'b0, acc} + {1'b0, active_rate};
  assign hit          = (sum >= WIN_EXT);
  assign acc_next     = hit ? COUNT_W'(sum - WIN_EXT) : sum[COUNT_W-1:0];
  assign win_end      = (cyc == WIN_LAST);
  assign accept       = cfg_valid & cfg_ready;
  assign rate_clamped = (cfg_rate > WIN) ? WIN : cfg_rate;

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      active_rate    <= '0;
      shadow_rate    <= '0;
      pending        <= 1'b0;
      acc            <= '0;
      cyc            <= '0;
      run_cnt        <= '0;
      cfg_ready      <= 1'b1;
      event_out      <= 1'b0;
      window_done    <= 1'b0;
      events_emitted <= '0;
      busy           <= 1'b0;
`ifdef SYNC_EVENT_GEN_ONE_SHOT_EN
      one_shot_q     <= 1'b0;
`endif
    end else begin
      event_out   <= 1'b0;
      window_done <= 1'b0;

      // Accept only happens while nothing is pending, so it never races an apply below.
      if (accept) begin
        shadow_rate <= rate_clamped;
        pending     <= 1'b1;
        cfg_ready   <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (pending) begin
            active_rate <= shadow_rate;
            pending     <= 1'b0;
            cfg_ready   <= 1'b1;
          end
          if (start) begin
            state <= ARM;
            busy  <= 1'b1;
`ifdef SYNC_EVENT_GEN_ONE_SHOT_EN
            one_shot_q <= one_shot;
`endif
          end else begin
            busy <= 1'b0;
          end
        end

        ARM: begin
          if (pending) begin
            active_rate <= shadow_rate;
            pending     <= 1'b0;
            cfg_ready   <= 1'b1;
          end
          acc     <= '0;
          cyc     <= '0;
          run_cnt <= '0;
          busy    <= 1'b1;
`ifdef SYNC_EVENT_GEN_ONE_SHOT_EN
          state   <= one_shot_q ? STOPPING : RUN;
`else
          state   <= RUN;
`endif
        end

        RUN, STOPPING: begin
          busy      <= 1'b1;
          event_out <= hit;
          if (win_end) begin
            window_done    <= 1'b1;
            events_emitted <= run_cnt + COUNT_W'(hit);
            acc            <= '0;
            cyc            <= '0;
            run_cnt        <= '0;
            if (pending) begin
              active_rate <= shadow_rate;
              pending     <= 1'b0;
              cfg_ready   <= 1'b1;
            end
            // A stop landing on the last cycle has already finished its window.
            if (state == STOPPING || stop) state <= IDLE;
          end else begin
            acc     <= acc_next;
            cyc     <= cyc + 1'b1;
            run_cnt <= run_cnt + COUNT_W'(hit);
            if (state == RUN && stop) state <= STOPPING;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sync_event_generator.sv
// tb/tb_sync_event_generator.sv - directed bench for sync_event_generator with WINDOW_CYCLES=10.
module tb_sync_event_generator;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [31:0] cfg_rate = '0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
`ifdef SYNC_EVENT_GEN_ONE_SHOT_EN
  logic        one_shot = 1'b0;
`endif
  logic        event_out;
  logic        window_done;
  logic [31:0] events_emitted;
  logic        busy;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sync_event_generator #(.WINDOW_CYCLES(10), .COUNT_W(32)) dut (
    .clk            (clk),
    .reset          (reset),
    .cfg_valid      (cfg_valid),
    .cfg_ready      (cfg_ready),
    .cfg_rate       (cfg_rate),
    .start          (start),
    .stop           (stop),
`ifdef SYNC_EVENT_GEN_ONE_SHOT_EN
    .one_shot       (one_shot),
`endif
    .event_out      (event_out),
    .window_done    (window_done),
    .events_emitted (events_emitted),
    .busy           (busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cfg(input logic [31:0] rate);
    cfg_valid = 1'b1;
    cfg_rate  = rate;
    step();
    cfg_valid = 1'b0;
    chk("cfg_ready_low_after_accept", {31'b0, cfg_ready}, 32'd0);
    step();
    chk("cfg_ready_high_after_idle_apply", {31'b0, cfg_ready}, 32'd1);
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
    chk("busy_in_arm", {31'b0, busy}, 32'd1);
    step();
  endtask

  // mask bit n = expected event for window cycle n; cfg_at/stop_at < 0 disables that stimulus.
  task automatic run_window(input logic [9:0] mask, input logic [31:0] emitted,
                            input int cfg_at, input logic [31:0] cfg_val, input int stop_at);
    logic exp_ready;
    for (int n = 0; n < 10; n++) begin
      if (n == cfg_at) begin
        cfg_valid = 1'b1;
        cfg_rate  = cfg_val;
      end
      if (n == stop_at) stop = 1'b1;
      step();
      cfg_valid = 1'b0;
      stop      = 1'b0;
      exp_ready = !(cfg_at >= 0 && n >= cfg_at && n < 9);
      chk($sformatf("event_out_c%0d", n), {31'b0, event_out}, {31'b0, mask[n]});
      chk($sformatf("window_done_c%0d", n), {31'b0, window_done}, {31'b0, (n == 9)});
      chk($sformatf("busy_c%0d", n), {31'b0, busy}, 32'd1);
      chk($sformatf("cfg_ready_c%0d", n), {31'b0, cfg_ready}, {31'b0, exp_ready});
    end
    chk("events_emitted", events_emitted, emitted);
  endtask

  initial begin
    reset = 1'b1;
    step();
    step();
    chk("rst_event_out", {31'b0, event_out}, 32'd0);
    chk("rst_window_done", {31'b0, window_done}, 32'd0);
    chk("rst_events_emitted", events_emitted, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_cfg_ready", {31'b0, cfg_ready}, 32'd1);
    reset = 1'b0;
    step();

    // Rate 3 free-running, then 7 offered mid-window, then back to 3 and stopped.
    cfg(32'd3);
    do_start();
    run_window(10'h248, 32'd3, -1, 32'd0, -1);
    run_window(10'h248, 32'd3, 4, 32'd7, -1);
    run_window(10'h3B6, 32'd7, 3, 32'd3, -1);
    run_window(10'h248, 32'd3, -1, 32'd0, 2);
    step();
    chk("stop_busy_low", {31'b0, busy}, 32'd0);
    chk("stop_event_out", {31'b0, event_out}, 32'd0);
    chk("stop_window_done", {31'b0, window_done}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("idle_no_event", {31'b0, event_out}, 32'd0);
    end
    chk("idle_emitted_held", events_emitted, 32'd3);

    // Rate 0 window, then 15 clamped to 10.
    cfg(32'd0);
    do_start();
    run_window(10'h000, 32'd0, 2, 32'd15, -1);
    run_window(10'h3FF, 32'd10, -1, 32'd0, 5);
    step();
    chk("clamp_busy_low", {31'b0, busy}, 32'd0);

    // Reset in the middle of a rate-5 window.
    cfg(32'd5);
    do_start();
    for (int n = 0; n < 5; n++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("midrst_event_out", {31'b0, event_out}, 32'd0);
    chk("midrst_window_done", {31'b0, window_done}, 32'd0);
    chk("midrst_events_emitted", events_emitted, 32'd0);
    chk("midrst_busy", {31'b0, busy}, 32'd0);
    chk("midrst_cfg_ready", {31'b0, cfg_ready}, 32'd1);
    for (int i = 0; i < 12; i++) begin
      step();
      chk("midrst_idle_window_done", {31'b0, window_done}, 32'd0);
      chk("midrst_idle_event", {31'b0, event_out}, 32'd0);
    end
    cfg(32'd5);
    do_start();
    run_window(10'h2AA, 32'd5, -1, 32'd0, 0);
    step();
    chk("rate5_busy_low", {31'b0, busy}, 32'd0);

`ifdef SYNC_EVENT_GEN_ONE_SHOT_EN
    cfg(32'd4);
    one_shot = 1'b1;
    do_start();
    one_shot = 1'b0;
    run_window(10'h294, 32'd4, -1, 32'd0, -1);
    step();
    chk("oneshot_busy_low", {31'b0, busy}, 32'd0);
    for (int i = 0; i < 12; i++) begin
      step();
      chk("oneshot_no_event", {31'b0, event_out}, 32'd0);
      chk("oneshot_no_window_done", {31'b0, window_done}, 32'd0);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
